isa_ram_arbiter: RTL and testbench

- Shares the single 32-bit RAM transaction port between NREQ ISA execution units (pop/push/load/store parts).
- Each unit keeps its native txs/txe two-phase handshake unchanged. The arbiter grants one unit at a time round-robin and holds the grant for the whole transaction.
- Non-granted units see txe held high, which stalls them in their "wait for txe low" state.

---
 rtl/isa_ram_arbiter_pkg.sv | 18 +
 rtl/isa_ram_arbiter_if.sv | 34 +++
 rtl/isa_ram_arbiter_rr_pick.sv | 40 ++++
 rtl/isa_ram_arbiter.sv | 124 ++++++++++++
 tb/tb_isa_ram_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_ram_arbiter_pkg.sv
// Shared types and constants for the ISA RAM-port arbiter.
package isa_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONNECT = 2'd1,
        BUSY    = 2'd2
    } state_e;

    localparam logic TXS_IDLE = 1'b1;
    localparam logic TXE_IDLE = 1'b1;

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/isa_ram_arbiter_if.sv
// Unit-side and RAM-side transaction signals seen by the arbiter.
interface isa_ram_arbiter_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 32
);
    logic [NREQ-1:0]        req_txs;
    logic [NREQ-1:0]        req_re;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wd;
    logic [NREQ-1:0]        req_txe;
    logic [DATA_W-1:0]      req_rd;

    logic                   ram_txs;
    logic                   ram_re;
    logic                   ram_we;
    logic [ADDR_W-1:0]      ram_addr;
    logic [DATA_W-1:0]      ram_wd;
    logic                   ram_txe;
    logic [DATA_W-1:0]      ram_rd;

    // Arbiter view.
    modport slave (
        input  req_txs, req_re, req_we, req_addr, req_wd, ram_txe, ram_rd,
        output req_txe, req_rd, ram_txs, ram_re, ram_we, ram_addr, ram_wd
    );

    // Environment view: units plus RAM.
    modport master (
        output req_txs, req_re, req_we, req_addr, req_wd, ram_txe, ram_rd,
        input  req_txe, req_rd, ram_txs, ram_re, ram_we, ram_addr, ram_wd
    );
endinterface

// File: rtl/isa_ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index strictly after ptr.
module rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  pending,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [NREQ-1:0] rot;
    logic [IDX_W-1:0] sel;

    // Position k of the rotated vector maps back to unit (ptr + 1 + k) mod NREQ.
    function automatic logic [IDX_W-1:0] src(input logic [IDX_W-1:0] p, input int k);
        return IDX_W'((int'(p) + 1 + k) % int'(NREQ));
    endfunction

    always_comb begin
        rot = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            rot[k] = pending[src(ptr, k)];
        end
    end

    always_comb begin
        valid = 1'b0;
        sel   = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                sel   = IDX_W'(k);
            end
        end
    end

    assign idx = src(ptr, int'(sel));

endmodule

// File: rtl/isa_ram_arbiter.sv
// Round-robin arbiter sharing one RAM txs/txe transaction port between NREQ units.
module isa_ram_arbiter
    import isa_arb_pkg::*;
#(
    parameter  int unsigned NREQ   = 4,
    parameter  int unsigned ADDR_W = 64,
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned IDX_W  = idx_w(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    isa_ram_arbiter_if.slave bus,
    output logic             busy,
    output logic [IDX_W-1:0] gnt_idx
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic             busy_q, busy_d;

    logic [NREQ-1:0]  pending;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             gnt_txs;

    assign pending = ~bus.req_txs;
    assign gnt_txs = bus.req_txs[gnt_q];

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .pending (pending),
        .ptr     (rr_q),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= IDX_W'(NREQ - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
        end
    end

    // Grant lifecycle; rr pointer moves only on a completed transaction.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid && bus.ram_txe) begin
                    gnt_d   = pick_idx;
                    state_d = CONNECT;
                    busy_d  = 1'b1;
                end
            end
            CONNECT: begin
                if (!bus.ram_txe) begin
                    state_d = BUSY;
                end else if (gnt_txs) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            BUSY: begin
                if (gnt_txs && bus.ram_txe) begin
                    state_d = IDLE;
                    rr_d    = gnt_q;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    logic              ram_txs, ram_re, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wd;
    logic [NREQ-1:0]   req_txe;

    // Pass-through mux; idle values whenever no grant is held.
    always_comb begin
        ram_txs  = TXS_IDLE;
        ram_re   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_wd   = '0;
        req_txe  = {NREQ{TXE_IDLE}};
        if (state_q != IDLE) begin
            ram_txs        = gnt_txs;
            ram_re         = bus.req_re[gnt_q];
            ram_we         = bus.req_we[gnt_q];
            ram_addr       = bus.req_addr[int'(gnt_q) * int'(ADDR_W) +: ADDR_W];
            ram_wd         = bus.req_wd[int'(gnt_q) * int'(DATA_W) +: DATA_W];
            req_txe[gnt_q] = bus.ram_txe;
        end
    end

    assign bus.ram_txs  = ram_txs;
    assign bus.ram_re   = ram_re;
    assign bus.ram_we   = ram_we;
    assign bus.ram_addr = ram_addr;
    assign bus.ram_wd   = ram_wd;
    assign bus.req_txe  = req_txe;
    assign bus.req_rd   = bus.ram_rd;

    assign busy    = busy_q;
    assign gnt_idx = gnt_q;

endmodule

// File: tb/tb_isa_ram_arbiter.sv
// Self-checking bench for isa_ram_arbiter: directed scenarios then random traffic vs a transaction-level model.
module tb_isa_ram_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   txs, re, we;
    logic [ADDR_W-1:0] addr [NREQ];
    logic [DATA_W-1:0] wd   [NREQ];
    logic              ram_txe;
    logic [DATA_W-1:0] ram_rd;
    logic              busy;
    logic [IDX_W-1:0]  gnt_idx;

    isa_ram_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    assign bus.req_txs = txs;
    assign bus.req_re  = re;
    assign bus.req_we  = we;
    assign bus.ram_txe = ram_txe;
    assign bus.ram_rd  = ram_rd;
    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign bus.req_addr[g*ADDR_W +: ADDR_W] = addr[g];
        assign bus.req_wd[g*DATA_W +: DATA_W]   = wd[g];
    end

    isa_ram_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .gnt_idx (gnt_idx)
    );

    // Transaction-level model: who owns the port, whether RAM accepted, who finished last.
    int owner;
    bit acc;
    int last;
    int last_gnt;
    int glog[$];
    bit [NREQ-1:0] rereq;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner    = -1;
        acc      = 1'b0;
        last     = int'(NREQ) - 1;
        last_gnt = 0;
    endtask

    task automatic model_update();
        if (!rst_n) begin
            model_reset();
        end else if (owner < 0) begin
            if (ram_txe) begin
                for (int k = 1; k <= int'(NREQ); k++) begin
                    int u;
                    u = (last + k) % int'(NREQ);
                    if (owner < 0 && !txs[u]) begin
                        owner    = u;
                        acc      = 1'b0;
                        last_gnt = u;
                        glog.push_back(u);
                    end
                end
            end
        end else if (!acc) begin
            if (!ram_txe)         acc = 1'b1;
            else if (txs[owner])  owner = -1;
        end else if (txs[owner] && ram_txe) begin
            last  = owner;
            owner = -1;
        end
    endtask

    task automatic check_all();
        logic [NREQ-1:0] e_txe;
        e_txe = '1;
        if (owner >= 0) begin
            e_txe[owner] = ram_txe;
            chk("ram_txs",  64'(bus.ram_txs),  64'(txs[owner]));
            chk("ram_re",   64'(bus.ram_re),   64'(re[owner]));
            chk("ram_we",   64'(bus.ram_we),   64'(we[owner]));
            chk("ram_addr", 64'(bus.ram_addr), 64'(addr[owner]));
            chk("ram_wd",   64'(bus.ram_wd),   64'(wd[owner]));
        end else begin
            chk("ram_txs",  64'(bus.ram_txs),  64'(1));
            chk("ram_re",   64'(bus.ram_re),   64'(0));
            chk("ram_we",   64'(bus.ram_we),   64'(0));
            chk("ram_addr", 64'(bus.ram_addr), 64'(0));
            chk("ram_wd",   64'(bus.ram_wd),   64'(0));
        end
        chk("req_txe", 64'(bus.req_txe), 64'(e_txe));
        chk("req_rd",  64'(bus.req_rd),  64'(ram_rd));
        chk("busy",    64'(busy),        64'(owner >= 0));
        chk("gnt_idx", 64'(gnt_idx),     64'(last_gnt));
    endtask

    // One clock: check outputs mid-cycle, advance model at the edge, return just after it.
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Behaves like the RAM plus granted unit: accept, then release+complete together.
    task automatic serve(input int n);
        for (int c = 0; c < n; c++) begin
            int rel;
            rel = -1;
            if (owner >= 0 && !acc) begin
                ram_txe = 1'b0;
            end else if (owner >= 0) begin
                ram_txe    = 1'b1;
                txs[owner] = 1'b1;
                rel        = owner;
            end else begin
                ram_txe = 1'b1;
            end
            step();
            if (rel >= 0 && rereq[rel]) begin
                txs[rel]   = 1'b0;
                rereq[rel] = 1'b0;
            end
        end
    endtask

    initial begin
        txs     = '1;
        re      = '0;
        we      = '0;
        ram_txe = 1'b1;
        ram_rd  = '0;
        rereq   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            addr[i] = '0;
            wd[i]   = '0;
        end
        do_reset();
        step();

        // Single read by unit 1.
        addr[1] = 64'h10;
        re[1]   = 1'b1;
        txs[1]  = 1'b0;
        step();
        chk("s1_busy", 64'(busy), 64'(1));
        chk("s1_gnt",  64'(gnt_idx), 64'(1));
        chk("s1_addr", 64'(bus.ram_addr), 64'h10);
        chk("s1_re",   64'(bus.ram_re), 64'(1));
        ram_txe = 1'b0;
        step();
        chk("s1_txe_lo", 64'(bus.req_txe), 64'hD);
        ram_rd  = 32'hDEADBEEF;
        ram_txe = 1'b1;
        txs[1]  = 1'b0;
        txs[1]  = 1'b1;
        #1;
        chk("s1_txe_hi", 64'(bus.req_txe[1]), 64'(1));
        chk("s1_rd",     64'(bus.req_rd), 64'hDEADBEEF);
        step();
        chk("s1_idle", 64'(busy), 64'(0));
        txs[1] = 1'b0;
        txs[2] = 1'b0;
        step();
        chk("s1_rr", 64'(gnt_idx), 64'(2));

        // Units 0,2,3 together from reset.
        txs = '1;
        re  = '0;
        do_reset();
        glog.delete();
        txs = 4'b0010;
        serve(20);
        chk("s2_n",  64'(glog.size()), 64'(3));
        if (glog.size() == 3) begin
            chk("s2_g0", 64'(glog[0]), 64'(0));
            chk("s2_g1", 64'(glog[1]), 64'(2));
            chk("s2_g2", 64'(glog[2]), 64'(3));
        end

        // Unit 0 re-requests immediately while unit 1 waits.
        glog.delete();
        txs      = 4'b1100;
        rereq[0] = 1'b1;
        serve(20);
        chk("s3_n", 64'(glog.size()), 64'(3));
        if (glog.size() == 3) begin
            chk("s3_g0", 64'(glog[0]), 64'(0));
            chk("s3_g1", 64'(glog[1]), 64'(1));
            chk("s3_g2", 64'(glog[2]), 64'(0));
        end

        // ram_txe low in IDLE blocks the grant.
        ram_txe = 1'b0;
        txs[2]  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s4_hold", 64'(busy), 64'(0));
        end
        ram_txe = 1'b1;
        step();
        chk("s4_busy", 64'(busy), 64'(1));
        chk("s4_gnt",  64'(gnt_idx), 64'(2));
        serve(6);

        // Unit 3 withdraws before acceptance.
        txs[3] = 1'b0;
        step();
        chk("s5_gnt", 64'(gnt_idx), 64'(3));
        txs[3] = 1'b1;
        #1;
        chk("s5_txe", 64'(bus.req_txe), 64'hF);
        step();
        chk("s5_idle", 64'(busy), 64'(0));
        txs[3] = 1'b0;
        txs[0] = 1'b0;
        step();
        chk("s5_rr", 64'(gnt_idx), 64'(3));
        serve(12);

        // Reset during BUSY.
        re[1]  = 1'b1;
        txs[1] = 1'b0;
        step();
        ram_txe = 1'b0;
        step();
        chk("s6_pre", 64'(busy), 64'(1));
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("s6_txs",  64'(bus.ram_txs), 64'(1));
        chk("s6_re",   64'(bus.ram_re),  64'(0));
        chk("s6_txe",  64'(bus.req_txe), 64'hF);
        chk("s6_busy", 64'(busy),        64'(0));
        ram_txe = 1'b1;
        txs[0]  = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("s6_gnt", 64'(gnt_idx), 64'(0));
        serve(12);

        // Random traffic with occasional resets.
        re = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                txs[i]  = ($urandom_range(0, 9) >= 4);
                re[i]   = 1'($urandom_range(0, 1));
                we[i]   = 1'($urandom_range(0, 1));
                addr[i] = {$urandom, $urandom};
                wd[i]   = $urandom;
            end
            ram_txe = 1'($urandom_range(0, 1));
            ram_rd  = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_all();
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
